regfile_writeback: RTL

//  Write side of the 16x32 register file: merges ALU results and load responses onto
//  the file's single write port (wEn1/wA1/wD1). Buffers load returns in a small FIFO and

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/wb_load_fifo.sv | 63 ++++++
 rtl/regfile_writeback.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write side.
// Used by regfile_writeback and its load-return FIFO.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int AW       = 4;
  localparam int NUM_REGS = 16;

  localparam logic [3:0] PC_REG = 4'd15;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LD
  } wb_src_e;

  // One-hot select of a register in the scoreboard.
  function automatic logic [NUM_REGS-1:0] regOneHot(
    input logic [AW-1:0] a
  );
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO buffering load returns ahead of the write port.
// Ports: clk, rst_n, push/pushData, pop/popData, full, empty, level.
module wb_load_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [LW-1:0]    count;
  logic             doPush;
  logic             doPop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign popData = mem[rdPtr];

  // A push while full is dropped even if a pop happens the same cycle.
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      unique case ({doPush, doPop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-port arbiter for the 16x32 register file: ALU results and
// buffered load returns share wEn1/wA1/wD1; r15 (PC) is never written.
// Ports: alu_* (valid/ready), ld_issue* (scoreboard set), ld_* (load
// return valid/ready), wEn1/wA1/wD1 (registered write), busy_mask,
// pc_wr_err (sticky), ld_level (FIFO occupancy).
// Option WB_BYPASS_EN adds byp_addr/byp_hit/byp_data forwarding.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int AW       = regfile_pkg::AW,
  parameter int LD_DEPTH = 4,
  parameter int LW       = $clog2(LD_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AW-1:0]     alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_issue,
  input  logic [AW-1:0]     ld_issue_addr,
  output logic              ld_issue_ready,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              wEn1,
  output logic [AW-1:0]     wA1,
  output logic [DATA_W-1:0] wD1,
`ifdef WB_BYPASS_EN
  input  logic [AW-1:0]     byp_addr,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data,
`endif
  output logic [15:0]       busy_mask,
  output logic              pc_wr_err,
  output logic [LW-1:0]     ld_level
);

  localparam int NR = 1 << AW;
  localparam int EW = AW + DATA_W;
  localparam logic [AW-1:0] PcAddr = AW'(PC_REG);

  logic [NR-1:0]     busy;
  logic [NR-1:0]     setMask;
  logic [NR-1:0]     clrMask;

  logic              fifoFull;
  logic              fifoEmpty;
  logic              fifoPush;
  logic              fifoPop;
  logic [EW-1:0]     headEnt;
  logic [AW-1:0]     headAddr;
  logic [DATA_W-1:0] headData;

  logic              aluBusy;
  logic              aluElig;
  logic              aluWin;
  logic              ldWin;
  logic              issueFire;
  logic              selPc;

  wb_src_e           wbSrc;
  logic [AW-1:0]     selAddr;
  logic [DATA_W-1:0] selData;

  wb_load_fifo #(
    .WIDTH (EW),
    .DEPTH (LD_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifoPush),
    .pushData ({ld_addr, ld_data}),
    .pop      (fifoPop),
    .popData  (headEnt),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .level    (ld_level)
  );

  assign headAddr = headEnt[EW-1:DATA_W];
  assign headData = headEnt[DATA_W-1:0];

  assign ld_ready = ~fifoFull;
  assign fifoPush = ld_valid & ld_ready;

  // ALU stalls on a pending load to its target (WAW) or a full FIFO.
  assign aluBusy   = busy[alu_addr];
  assign alu_ready = ~aluBusy & ~(fifoFull & ~fifoEmpty);
  assign aluElig   = alu_valid & ~aluBusy;

  assign ld_issue_ready = ~busy[ld_issue_addr] &
                          (ld_issue_addr != PcAddr);
  assign issueFire = ld_issue & ld_issue_ready;

  // A full FIFO pre-empts the ALU so load returns cannot back up.
  assign aluWin = ~fifoFull & aluElig;
  assign ldWin  = fifoFull | (~aluElig & ~fifoEmpty);

  always_comb begin
    wbSrc   = WB_NONE;
    selAddr = '0;
    selData = '0;
    unique case (1'b1)
      aluWin: begin
        wbSrc   = WB_ALU;
        selAddr = alu_addr;
        selData = alu_data;
      end
      ldWin: begin
        wbSrc   = WB_LD;
        selAddr = headAddr;
        selData = headData;
      end
      default: begin
        wbSrc = WB_NONE;
      end
    endcase
  end

  assign fifoPop = (wbSrc == WB_LD);
  assign selPc   = (wbSrc != WB_NONE) & (selAddr == PcAddr);

  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (issueFire) begin
      setMask = NR'(regOneHot(regfile_pkg::AW'(ld_issue_addr)));
    end
    if (wbSrc == WB_LD) begin
      clrMask = NR'(regOneHot(regfile_pkg::AW'(headAddr)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      wEn1      <= 1'b0;
      wA1       <= '0;
      wD1       <= '0;
      pc_wr_err <= 1'b0;
    end else begin
      // Set applied after clear so a same-cycle re-issue stays pending.
      busy <= (busy & ~clrMask) | setMask;
      wEn1 <= (wbSrc != WB_NONE) & ~selPc;
      if ((wbSrc != WB_NONE) && !selPc) begin
        wA1 <= selAddr;
        wD1 <= selData;
      end
      if (selPc) begin
        pc_wr_err <= 1'b1;
      end
    end
  end

  assign busy_mask = 16'(busy);

`ifdef WB_BYPASS_EN
  assign byp_hit  = wEn1 & (wA1 == byp_addr);
  assign byp_data = wD1;
`endif

endmodule
